// File: rtl/fft_tx_serializer.sv
// fft_tx_serializer: captures one FFT frame and streams it to a UART
// transmitter one byte at a time, handshaking with start/done pulses.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst          synchronous active-high reset
//   i_frame_valid  one-cycle pulse: i_frame holds a complete FFT result
//   i_frame        flattened frame, word k at [k*WORD_SIZE +: WORD_SIZE]
//   i_tx_done      one-cycle pulse from the UART: current byte finished
//   o_tx_start     one-cycle request to send o_tx_byte
//   o_tx_byte      byte being transmitted (held until its i_tx_done)
//   o_busy         high while a frame is being serialized
//   o_frame_sent   one-cycle pulse when the last byte completes
//   o_frame_drop   one-cycle pulse when a frame arrives while busy
module fft_tx_serializer #(
  parameter int unsigned FFT_SIZE    = 16,
  parameter int unsigned WORD_SIZE   = 16,
  parameter int unsigned DATA_LENGTH = 8
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_frame_valid,
  input  logic [FFT_SIZE*WORD_SIZE-1:0]   i_frame,
  input  logic                            i_tx_done,
  output logic                            o_tx_start,
  output logic [DATA_LENGTH-1:0]          o_tx_byte,
  output logic                            o_busy,
  output logic                            o_frame_sent,
  output logic                            o_frame_drop
);

  localparam int unsigned FRAME_W  = FFT_SIZE * WORD_SIZE;
  localparam int unsigned NBYTES   = FRAME_W / DATA_LENGTH;
  localparam int unsigned IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         index_q, index_d;
  logic [FRAME_W-1:0]       frame_q, frame_d;
  logic                     tx_start_q, tx_start_d;
  logic [DATA_LENGTH-1:0]   tx_byte_q, tx_byte_d;
  logic                     busy_q, busy_d;
  logic                     frame_sent_q, frame_sent_d;
  logic                     frame_drop_q, frame_drop_d;
  logic                     last_done;

  // Final byte of the frame acknowledged by the transmitter this cycle.
  assign last_done = (state_q == S_WAIT) && i_tx_done && (index_q >= LAST_IDX);

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      index_q      <= '0;
      frame_q      <= '0;
      tx_start_q   <= 1'b0;
      tx_byte_q    <= '0;
      busy_q       <= 1'b0;
      frame_sent_q <= 1'b0;
      frame_drop_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      frame_q      <= frame_d;
      tx_start_q   <= tx_start_d;
      tx_byte_q    <= tx_byte_d;
      busy_q       <= busy_d;
      frame_sent_q <= frame_sent_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  // Next state, byte index and frame capture.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    frame_d = frame_q;
    case (state_q)
      S_IDLE: begin
        if (i_frame_valid) begin
          frame_d = i_frame;
          index_d = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_tx_done) begin
          if (index_q < LAST_IDX) begin
            index_d = index_q + IDX_W'(1);
            state_d = S_START;
          end else if (i_frame_valid) begin
            // A frame arriving with the final done is accepted immediately.
            frame_d = i_frame;
            index_d = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the next state so that each one
  // lines up with the cycle in which the FSM occupies that state.
  always_comb begin
    tx_start_d   = (state_d == S_START);
    busy_d       = (state_d != S_IDLE);
    frame_sent_d = last_done;
    frame_drop_d = i_frame_valid && (state_q != S_IDLE) && !last_done;
    tx_byte_d    = DATA_LENGTH'(frame_d >> (32'(index_d) * DATA_LENGTH));
  end

  assign o_tx_start   = tx_start_q;
  assign o_tx_byte    = tx_byte_q;
  assign o_busy       = busy_q;
  assign o_frame_sent = frame_sent_q;
  assign o_frame_drop = frame_drop_q;

endmodule

// File: tb/tb_fft_tx_serializer.sv
// tb_fft_tx_serializer: scoreboard bench for fft_tx_serializer at default
// parameters (16 words x 16 bits, 8-bit bytes, 32 bytes per frame).
module tb_fft_tx_serializer;

  localparam int unsigned NW = 16;
  localparam int unsigned FW = 256;

  typedef logic [15:0] word_arr_t [NW];

  logic            clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_frame_valid = 1'b0;
  logic [FW-1:0]   i_frame = '0;
  logic            i_tx_done = 1'b0;
  logic            o_tx_start;
  logic [7:0]      o_tx_byte;
  logic            o_busy;
  logic            o_frame_sent;
  logic            o_frame_drop;

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;
  int n_sent   = 0;
  int n_drop   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] cur_byte = 8'h00;

  fft_tx_serializer #(.FFT_SIZE(16), .WORD_SIZE(16), .DATA_LENGTH(8)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_frame_valid(i_frame_valid),
    .i_frame      (i_frame),
    .i_tx_done    (i_tx_done),
    .o_tx_start   (o_tx_start),
    .o_tx_byte    (o_tx_byte),
    .o_busy       (o_busy),
    .o_frame_sent (o_frame_sent),
    .o_frame_drop (o_frame_drop)
  );

  always #5 clk = ~clk;

  // Scoreboard: every start pops the next expected byte; between starts the
  // byte must hold while busy.
  always @(negedge clk) begin
    if (o_tx_start === 1'b1) begin
      n_starts++;
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_start: got byte %h, want no start", o_tx_byte);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        cur_byte = e;
        if (o_tx_byte === e) n_pass++;
        else $display("FAIL start_byte: got %h want %h", o_tx_byte, e);
      end
    end else if (o_busy === 1'b1) begin
      n_checks++;
      if (o_tx_byte === cur_byte) n_pass++;
      else $display("FAIL byte_hold: got %h want %h", o_tx_byte, cur_byte);
    end
    if (o_frame_sent === 1'b1) n_sent++;
    if (o_frame_drop === 1'b1) n_drop++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] pack_frame(input word_arr_t w);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NW; k++) f[k*16 +: 16] = w[k];
    return f;
  endfunction

  // Byte 2k is the low byte of word k, byte 2k+1 its high byte.
  task automatic push_expected(input word_arr_t w);
    for (int k = 0; k < NW; k++) begin
      exp_q.push_back(w[k][7:0]);
      exp_q.push_back(w[k][15:8]);
    end
  endtask

  task automatic pulse_valid(input logic [FW-1:0] f);
    i_frame = f;
    i_frame_valid = 1'b1;
    tick();
    i_frame_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (o_tx_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // Answers n byte requests, returning done dly cycles after each start.
  task automatic serve(input int n, input int dly, output int tmo);
    bit ok;
    tmo = 0;
    for (int b = 0; b < n; b++) begin
      wait_start(ok);
      if (!ok) begin
        tmo++;
        break;
      end
      repeat (dly) tick();
      i_tx_done = 1'b1;
      tick();
      i_tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) tick();
    n_checks++;
    if ({o_tx_start, o_busy, o_frame_sent, o_frame_drop} === 4'b0) n_pass++;
    else $display("FAIL reset_flags: got %b want 0000",
                  {o_tx_start, o_busy, o_frame_sent, o_frame_drop});
    n_checks++;
    if (o_tx_byte === 8'h00) n_pass++;
    else $display("FAIL reset_byte: got %h want 00", o_tx_byte);
    i_rst = 1'b0;
    tick();
    n_checks++;
    if (o_busy === 1'b0) n_pass++;
    else $display("FAIL idle_busy: got %b want 0", o_busy);
  endtask

  task automatic test_full_frame();
    word_arr_t w;
    int tmo, s0, f0;
    for (int k = 0; k < NW; k++) w[k] = 16'(16'h0100 * k + k);
    s0 = n_starts;
    f0 = n_sent;
    push_expected(w);
    pulse_valid(pack_frame(w));
    serve(32, 5, tmo);
    n_checks++;
    if (tmo === 0) n_pass++;
    else $display("FAIL full_timeout: got %0d want 0", tmo);
    n_checks++;
    if (o_frame_sent === 1'b1 && o_busy === 1'b0) n_pass++;
    else $display("FAIL full_end: got sent=%b busy=%b want sent=1 busy=0",
                  o_frame_sent, o_busy);
    tick();
    n_checks++;
    if (n_starts - s0 === 32) n_pass++;
    else $display("FAIL full_starts: got %0d want 32", n_starts - s0);
    n_checks++;
    if (n_sent - f0 === 1 && o_frame_sent === 1'b0) n_pass++;
    else $display("FAIL full_sent: got %0d want 1", n_sent - f0);
    n_checks++;
    if (exp_q.size() === 0) n_pass++;
    else $display("FAIL full_queue: got %0d want 0", exp_q.size());
  endtask

  task automatic test_latency();
    word_arr_t w;
    int tmo;
    for (int k = 0; k < NW; k++) w[k] = 16'(16'h1111 * k);
    w[0] = 16'hA500;
    push_expected(w);
    pulse_valid(pack_frame(w));
    n_checks++;
    if (o_tx_start === 1'b1 && o_tx_byte === 8'h00) n_pass++;
    else $display("FAIL lat_first: got start=%b byte=%h want 1/00", o_tx_start, o_tx_byte);
    for (int i = 0; i < 9; i++) begin
      tick();
      n_checks++;
      if (o_tx_start === 1'b0 && o_tx_byte === 8'h00) n_pass++;
      else $display("FAIL lat_hold: got start=%b byte=%h want 0/00", o_tx_start, o_tx_byte);
    end
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    n_checks++;
    if (o_tx_start === 1'b1 && o_tx_byte === 8'hA5) n_pass++;
    else $display("FAIL lat_next: got start=%b byte=%h want 1/a5", o_tx_start, o_tx_byte);
    serve(31, 2, tmo);
    tick();
    n_checks++;
    if (tmo === 0 && exp_q.size() === 0) n_pass++;
    else $display("FAIL lat_drain: got tmo=%0d q=%0d want 0/0", tmo, exp_q.size());
  endtask

  task automatic test_drop();
    word_arr_t a, b;
    int tmo, d0, f0;
    bit ok;
    for (int k = 0; k < NW; k++) begin
      a[k] = 16'($urandom);
      b[k] = ~a[k];
    end
    d0 = n_drop;
    f0 = n_sent;
    push_expected(a);
    pulse_valid(pack_frame(a));
    serve(5, 3, tmo);
    wait_start(ok);
    tick();
    pulse_valid(pack_frame(b));
    n_checks++;
    if (o_frame_drop === 1'b1) n_pass++;
    else $display("FAIL drop_pulse: got %b want 1", o_frame_drop);
    tick();
    n_checks++;
    if (o_frame_drop === 1'b0) n_pass++;
    else $display("FAIL drop_width: got %b want 0", o_frame_drop);
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    serve(26, 2, tmo);
    tick();
    n_checks++;
    if (ok && tmo === 0 && n_drop - d0 === 1 && n_sent - f0 === 1) n_pass++;
    else $display("FAIL drop_totals: got drops=%0d sent=%0d tmo=%0d want 1/1/0",
                  n_drop - d0, n_sent - f0, tmo);
  endtask

  task automatic test_back_to_back();
    word_arr_t a, b;
    int tmo, f0, d0;
    bit ok;
    for (int k = 0; k < NW; k++) begin
      a[k] = 16'($urandom);
      b[k] = 16'($urandom);
    end
    b[0][7:0] = 8'h5C;
    f0 = n_sent;
    d0 = n_drop;
    push_expected(a);
    pulse_valid(pack_frame(a));
    serve(31, 2, tmo);
    wait_start(ok);
    repeat (2) tick();
    push_expected(b);
    i_frame = pack_frame(b);
    i_frame_valid = 1'b1;
    i_tx_done = 1'b1;
    tick();
    i_frame_valid = 1'b0;
    i_tx_done = 1'b0;
    n_checks++;
    if (o_frame_sent === 1'b1 && o_frame_drop === 1'b0) n_pass++;
    else $display("FAIL b2b_flags: got sent=%b drop=%b want 1/0", o_frame_sent, o_frame_drop);
    n_checks++;
    if (o_tx_start === 1'b1 && o_tx_byte === 8'h5C && o_busy === 1'b1) n_pass++;
    else $display("FAIL b2b_start: got start=%b byte=%h busy=%b want 1/5c/1",
                  o_tx_start, o_tx_byte, o_busy);
    serve(32, 2, tmo);
    tick();
    n_checks++;
    if (ok && tmo === 0 && n_sent - f0 === 2 && n_drop - d0 === 0) n_pass++;
    else $display("FAIL b2b_totals: got sent=%0d drops=%0d tmo=%0d want 2/0/0",
                  n_sent - f0, n_drop - d0, tmo);
  endtask

  task automatic test_reset_mid();
    word_arr_t a;
    int tmo, s0, f0;
    bit ok;
    for (int k = 0; k < NW; k++) a[k] = 16'($urandom) | 16'h0101;
    push_expected(a);
    pulse_valid(pack_frame(a));
    serve(12, 2, tmo);
    wait_start(ok);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    exp_q.delete();
    s0 = n_starts;
    f0 = n_sent;
    n_checks++;
    if ({o_tx_start, o_busy, o_frame_sent, o_frame_drop} === 4'b0 && o_tx_byte === 8'h00)
      n_pass++;
    else $display("FAIL mid_reset: got flags=%b byte=%h want 0000/00",
                  {o_tx_start, o_busy, o_frame_sent, o_frame_drop}, o_tx_byte);
    for (int i = 0; i < 16; i++) begin
      i_tx_done = (i % 4 == 1);
      tick();
      n_checks++;
      if ({o_tx_start, o_busy, o_frame_sent} === 3'b0) n_pass++;
      else $display("FAIL stray_done: got %b want 000", {o_tx_start, o_busy, o_frame_sent});
    end
    i_tx_done = 1'b0;
    i_rst = 1'b1;
    i_frame_valid = 1'b1;
    tick();
    i_rst = 1'b0;
    i_frame_valid = 1'b0;
    tick();
    n_checks++;
    if ({o_tx_start, o_busy} === 2'b0) n_pass++;
    else $display("FAIL rst_priority: got %b want 00", {o_tx_start, o_busy});
    n_checks++;
    if (ok && tmo === 0 && n_starts - s0 === 0 && n_sent - f0 === 0) n_pass++;
    else $display("FAIL mid_totals: got starts=%0d sent=%0d want 0/0",
                  n_starts - s0, n_sent - f0);
  endtask

  task automatic test_isolation();
    word_arr_t a;
    int tmo, f0;
    bit ok;
    for (int k = 0; k < NW; k++) a[k] = 16'($urandom) & 16'h7F7F;
    f0 = n_sent;
    push_expected(a);
    pulse_valid(pack_frame(a));
    i_frame = '1;
    wait_start(ok);
    // Done during the start cycle must not advance the index.
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    n_checks++;
    if (o_tx_start === 1'b0 && o_busy === 1'b1 && exp_q.size() === 31) n_pass++;
    else $display("FAIL start_done: got start=%b busy=%b q=%0d want 0/1/31",
                  o_tx_start, o_busy, exp_q.size());
    i_tx_done = 1'b1;
    tick();
    i_tx_done = 1'b0;
    serve(31, int'($urandom_range(1, 3)), tmo);
    tick();
    n_checks++;
    if (ok && tmo === 0 && n_sent - f0 === 1 && exp_q.size() === 0) n_pass++;
    else $display("FAIL iso_totals: got sent=%0d q=%0d tmo=%0d want 1/0/0",
                  n_sent - f0, exp_q.size(), tmo);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_latency();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_isolation();
    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
